packing_data_register: RTL

Parametrised successor to the team's byte-loading data register. Accepts an `IN_WIDTH`-bit input lane and builds a `WIDTH`-bit word using extend-load, shift-insert and rotate operations. Tracks how many lanes have been inserted since the last load or acknowledge, and flags a completed word and an overrun. Sits between byte-wide memory/bus sources and the datapath, wherever a word is assembled from consecutive byte transfers.

---
 rtl/packing_data_register_if.sv | 28 ++
 rtl/packing_data_register.sv | 95 +++++++++
 2 files changed

// File: rtl/packing_data_register_if.sv
// Bus bundle for packing_data_register: operation/lane inputs from the producer,
// assembled word and status back to it.
interface packing_data_register_if #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8
);
  localparam int LANES = WIDTH / IN_WIDTH;
  localparam int CW    = $clog2(LANES + 1);

  logic                E;
  logic [2:0]          FunSel;
  logic [IN_WIDTH-1:0] In;
  logic                Ack;
  logic [WIDTH-1:0]    Out;
  logic [CW-1:0]       Count;
  logic                Full;
  logic                Overrun;

  modport master (
    output E, FunSel, In, Ack,
    input  Out, Count, Full, Overrun
  );

  modport slave (
    input  E, FunSel, In, Ack,
    output Out, Count, Full, Overrun
  );
endinterface

// File: rtl/packing_data_register.sv
// Word-assembling data register: extend-loads, shift-inserts and rotates IN_WIDTH lanes
// into a WIDTH-bit word, counting inserted lanes and flagging full/overrun.
module packing_data_register #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  packing_data_register_if.slave bus
);
  localparam int LANES = WIDTH / IN_WIDTH;
  localparam int CW    = $clog2(LANES + 1);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [2:0] {
    OP_SEXT = 3'b000,
    OP_ZEXT = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_CLR  = 3'b100,
    OP_HOLD = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } op_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full;
  logic             ack_take;
  op_e              op;

  assign op       = op_e'(bus.FunSel);
  assign full     = (count_q == LANES_C);
  assign ack_take = bus.Ack && full;

  // A consumed word restarts the count unless the operation sets it itself;
  // a shift-insert together with Ack starts a fresh word instead of overrunning.
  always_comb begin
    out_d     = out_q;
    count_d   = ack_take ? '0 : count_q;
    overrun_d = overrun_q;
    if (bus.E) begin
      case (op)
        OP_SEXT: begin
          out_d   = {{(WIDTH-IN_WIDTH){bus.In[IN_WIDTH-1]}}, bus.In};
          count_d = ONE_C;
        end
        OP_ZEXT: begin
          out_d   = {{(WIDTH-IN_WIDTH){1'b0}}, bus.In};
          count_d = ONE_C;
        end
        OP_SHL, OP_SHR: begin
          if (op == OP_SHL) out_d = {out_q[WIDTH-IN_WIDTH-1:0], bus.In};
          else              out_d = {bus.In, out_q[WIDTH-1:IN_WIDTH]};
          if (ack_take) begin
            count_d = ONE_C;
          end else if (full) begin
            count_d   = LANES_C;
            overrun_d = 1'b1;
          end else begin
            count_d = count_q + ONE_C;
          end
        end
        OP_CLR: begin
          out_d     = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end
        OP_HOLD: begin
        end
        OP_ROL: out_d = {out_q[WIDTH-IN_WIDTH-1:0], out_q[WIDTH-1:WIDTH-IN_WIDTH]};
        OP_ROR: out_d = {out_q[IN_WIDTH-1:0], out_q[WIDTH-1:IN_WIDTH]};
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.Out     = out_q;
  assign bus.Count   = count_q;
  assign bus.Full    = full;
  assign bus.Overrun = overrun_q;
endmodule
